vga_text_renderer: RTL and testbench
====================================

// Module: vga_text_renderer
// PURPOSE
//   Text-mode pixel stage downstream of the VGA timing generator. Takes the
//   generator's x/y/hs/vs and fetches character codes from an 80x30 char RAM
//   and bitmaps from an 8x16 font ROM, through synchronous read ports. Drives
//   9-bit RGB, with hs/vs delayed to stay aligned with the pixel data.
//   Supports a per-cell inverse attribute and a blinking underline cursor.
// PARAMETERS
//   H_RES       640     active pixels per line
//   V_RES       480     active lines per frame
//   COLS        80      character cells per row (H_RES/8)
//   FG_COLOR    9'h1FF  foreground rgb {r[2:0],g[2:0],b[2:0]}
//   BG_COLOR    9'h000  background rgb
//   BLINK_LOG2  5       cursor toggles every 2**BLINK_LOG2 frames
// PORTS
//   clk         in   1   pixel clock, ~25.175 MHz, same net as timing generator
//   rst         in   1   reset, asynchronous, active-low
//   x_in        in   11  pixel column from timing generator
//   y_in        in   11  pixel line from timing generator
//   hs_in       in   1   hsync from timing generator, active-low
//   vs_in       in   1   vsync from timing generator, active-low
//   char_addr   out  12  char RAM read address, row*COLS+col
//   char_data   in   8   char RAM data: [6:0] code, [7] inverse
//   font_addr   out  11  font ROM address {code[6:0], line[3:0]}
//   font_data   in   8   font row, bit 7 = leftmost pixel
//   cursor_en   in   1   cursor enable
//   cursor_col  in   7   cursor cell column, 0..COLS-1
//   cursor_row  in   5   cursor cell row, 0..29
//   rgb         out  9   pixel colour
//   hs_out      out  1   hsync, delayed to align with rgb
//   vs_out      out  1   vsync, delayed to align with rgb
// BEHAVIOUR
//   - All registers update on posedge clk. The generator updates on negedge,
//     which gives half a cycle of setup.
//   - Reset values (rst low, asynchronous): rgb=0, hs_out=1, vs_out=1,
//     char_addr=0, font_addr=0. All pipeline stages are cleared to blank
//     with hs/vs=1. The frame counter is cleared to 0.
//   - Stage S0 (input edge):
//     - Register char_addr = (y_in>>4)*COLS + (x_in>>3) when active
//       (x_in<H_RES && y_in<V_RES), else char_addr=0.
//     - Multiply as (row<<6)+(row<<4) for COLS=80.
//     - Carry forward x[2:0], y[3:0], cell col/row, active, hs_in, vs_in.
//   - Stage S1: char RAM returns char_data (1-cycle read latency).
//     - Register font_addr = {char_data[6:0], y[3:0]}.
//     - Carry forward inv=char_data[7] and the S0 sideband.
//   - Stage S2: font ROM returns font_data (1-cycle read latency).
//     - pix = font_data[7 - x[2:0]].
//     - cur = cursor_en & blink & cell==(cursor_col,cursor_row) & y[3:0]>=14.
//     - on = pix ^ inv ^ cur.
//     - Register rgb = active ? (on ? FG_COLOR : BG_COLOR) : 9'h000.
//   - Latency: exactly 3 clk from an (x_in,y_in,hs_in,vs_in) sample to the
//     matching rgb/hs_out/vs_out. hs_out and vs_out are pure 3-cycle delays
//     of the inputs.
//   - Blank region: rgb is forced to 0 whenever the sampled pixel is outside
//     the active area, regardless of RAM/ROM data. This covers x=640..799
//     and y=480..524.
//   - Blink:
//     - frame_cnt[BLINK_LOG2:0] increments on each falling edge of vs_in,
//       detected against the S0 registered copy.
//     - Wraps from all-ones to 0.
//     - blink = frame_cnt[BLINK_LOG2].
//   - Cursor row/col values out of range never match; no cursor is drawn.
//   - Cursor inputs are sampled at S2, so a change takes effect at the next
//     pixel.
//   - Reset mid-frame: outputs return to reset values immediately. After rst
//     releases, the first valid rgb appears 3 clk after the first sampled
//     input. No stale pixel is emitted.
// TESTING
//   1 Char RAM model all 8'h41, font row 8'h81, x=0..7,y=0
//     -> rgb FG,BG x6,FG at cycles 3..10.
//   2 Char 8'hC1 (inverse), same font -> rgb BG,FG x6,BG; inverse applies
//     only to that cell.
//   3 Address check: (x,y)=(639,479) -> char_addr=2399; (0,16) -> 80;
//     (8,0) -> 1; (640,0) -> 0.
//   4 Full 800x525 frame with font data all-ones -> rgb=0 exactly in the
//     blank region; hs_out/vs_out equal hs_in/vs_in delayed 3 clk, bit-exact.
//   5 cursor_en=1 at (5,2), blank font:
//     - frames 32..63 -> FG at x 40..47, y 46..47 only.
//     - frames 0..31 -> all BG.
//   6 rst asserted at x=300,y=200 for 5 clk -> rgb=0, hs_out=vs_out=1
//     immediately; frame_cnt=0; correct pixels resume 3 clk after release.

Source files
------------

// File: rtl/vga_text_renderer.sv
// Text-mode pixel stage: turns timing-generator coordinates into character-cell
// RGB through a char RAM and font ROM, with per-cell inverse and a blinking cursor.
module vga_text_renderer #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          COLS       = 80,
  parameter logic [8:0]  FG_COLOR   = 9'h1FF,
  parameter logic [8:0]  BG_COLOR   = 9'h000,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x_in,
  input  logic [10:0] y_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [8:0]  rgb,
  output logic        hs_out,
  output logic        vs_out
);

  localparam logic [10:0] H_LIM   = 11'(H_RES);
  localparam logic [10:0] V_LIM   = 11'(V_RES);
  localparam logic [6:0]  COL_LIM = 7'(COLS);
  localparam logic [5:0]  ROW_LIM = 6'(V_RES / 16);

  function automatic logic [8:0] pixel_color(input logic act, input logic on);
    if (!act) return 9'h000;
    return on ? FG_COLOR : BG_COLOR;
  endfunction

  // S0 state
  logic [11:0] char_addr_q, char_addr_d;
  logic [2:0]  xl_p0_q;
  logic [3:0]  yl_p0_q;
  logic [6:0]  col_p0_q;
  logic [5:0]  row_p0_q;
  logic        act_p0_q, hs_p0_q, vs_p0_q;
  logic        act_d;

  // S1 state
  logic [10:0] font_addr_q, font_addr_d;
  logic        inv_p1_q;
  logic [2:0]  xl_p1_q;
  logic [3:0]  yl_p1_q;
  logic [6:0]  col_p1_q;
  logic [5:0]  row_p1_q;
  logic        act_p1_q, hs_p1_q, vs_p1_q;

  // S2 state
  logic [8:0]  rgb_q, rgb_d;
  logic        hs_p2_q, vs_p2_q;

  logic [BLINK_LOG2:0] frame_cnt_q, frame_cnt_d;
  logic        blink, vs_fall;
  logic        pix, cell_hit, cur, on;
  logic [11:0] row_w, col_w;

  // ---- S0: cell address from incoming coordinates
  always_comb begin
    act_d = (x_in < H_LIM) && (y_in < V_LIM);
    row_w = {5'd0, y_in[10:4]};
    col_w = {4'd0, x_in[10:3]};
    // row*80 as two shifts keeps the multiplier out of the pixel path
    char_addr_d = act_d ? ((row_w << 6) + (row_w << 4) + col_w) : 12'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_addr_q <= 12'd0;
      xl_p0_q     <= 3'd0;
      yl_p0_q     <= 4'd0;
      col_p0_q    <= 7'd0;
      row_p0_q    <= 6'd0;
      act_p0_q    <= 1'b0;
      hs_p0_q     <= 1'b1;
      vs_p0_q     <= 1'b1;
    end else begin
      char_addr_q <= char_addr_d;
      xl_p0_q     <= x_in[2:0];
      yl_p0_q     <= y_in[3:0];
      col_p0_q    <= x_in[9:3];
      row_p0_q    <= y_in[9:4];
      act_p0_q    <= act_d;
      hs_p0_q     <= hs_in;
      vs_p0_q     <= vs_in;
    end
  end

  // Frame counter advances on the vsync falling edge seen at the input
  always_comb begin
    vs_fall     = vs_p0_q & ~vs_in;
    frame_cnt_d = frame_cnt_q + {{BLINK_LOG2{1'b0}}, vs_fall};
    blink       = frame_cnt_q[BLINK_LOG2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt_q <= '0;
    else      frame_cnt_q <= frame_cnt_d;
  end

  // ---- S1: char RAM data in, font address out
  always_comb begin
    font_addr_d = {char_data[6:0], yl_p0_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      font_addr_q <= 11'd0;
      inv_p1_q    <= 1'b0;
      xl_p1_q     <= 3'd0;
      yl_p1_q     <= 4'd0;
      col_p1_q    <= 7'd0;
      row_p1_q    <= 6'd0;
      act_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
    end else begin
      font_addr_q <= font_addr_d;
      inv_p1_q    <= char_data[7];
      xl_p1_q     <= xl_p0_q;
      yl_p1_q     <= yl_p0_q;
      col_p1_q    <= col_p0_q;
      row_p1_q    <= row_p0_q;
      act_p1_q    <= act_p0_q;
      hs_p1_q     <= hs_p0_q;
      vs_p1_q     <= vs_p0_q;
    end
  end

  // ---- S2: font bit select, cursor overlay, colour
  always_comb begin
    pix      = font_data[3'd7 - xl_p1_q];
    // out-of-range cursor coordinates must never light a cell
    cell_hit = (col_p1_q == cursor_col) && (row_p1_q == {1'b0, cursor_row}) &&
               (cursor_col < COL_LIM) && ({1'b0, cursor_row} < ROW_LIM);
    cur      = cursor_en & blink & cell_hit & (yl_p1_q >= 4'd14);
    on       = pix ^ inv_p1_q ^ cur;
    rgb_d    = pixel_color(act_p1_q, on);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q   <= 9'h000;
      hs_p2_q <= 1'b1;
      vs_p2_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hs_p2_q <= hs_p1_q;
      vs_p2_q <= vs_p1_q;
    end
  end

  assign char_addr = char_addr_q;
  assign font_addr = font_addr_q;
  assign rgb       = rgb_q;
  assign hs_out    = hs_p2_q;
  assign vs_out    = vs_p2_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: drives coordinates on negedge like the
// timing generator and checks outputs three clocks later.
module tb_vga_text_renderer;

  localparam logic [8:0] FG = 9'h1FF;
  localparam logic [8:0] BG = 9'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x_in = 11'd800;
  logic [10:0] y_in = 11'd500;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = 7'd0;
  logic [4:0]  cursor_row = 5'd0;
  logic [8:0]  rgb;
  logic        hs_out, vs_out;

  logic [11:0] inv_addr = 12'hFFF;
  logic [7:0]  font_val = 8'h81;

  int n_cmp = 0;
  int n_err = 0;

  // Every cell holds 'A' (0x41); one selectable cell carries the inverse bit.
  assign char_data = {char_addr == inv_addr, 7'h41};
  assign font_data = (font_addr[10:4] == 7'h41) ? font_val : 8'h00;

  vga_text_renderer dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .hs_in(hs_in), .vs_in(vs_in),
    .char_addr(char_addr), .char_data(char_data), .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out)
  );

  initial forever #20 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [8:0]  rgb;
    logic        hs;
    logic        vs;
    logic [11:0] ca;
    logic [10:0] fa;
    bit          chk;
    bit          chka;
  } exp_t;

  exp_t pipe[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input int x, input int y, input logic hs, input logic vs,
                        input logic [8:0] er, input bit chka,
                        input logic [11:0] eca, input logic [10:0] efa);
    exp_t e;
    @(negedge clk);
    if (pipe[0].chka)
      chk($sformatf("char_addr x=%0d y=%0d", pipe[0].x, pipe[0].y), 32'(char_addr), 32'(pipe[0].ca));
    if (pipe[1].chka)
      chk($sformatf("font_addr x=%0d y=%0d", pipe[1].x, pipe[1].y), 32'(font_addr), 32'(pipe[1].fa));
    if (pipe[2].chk) begin
      chk($sformatf("rgb x=%0d y=%0d", pipe[2].x, pipe[2].y), 32'(rgb), 32'(pipe[2].rgb));
      chk($sformatf("hs_out x=%0d y=%0d", pipe[2].x, pipe[2].y), 32'(hs_out), 32'(pipe[2].hs));
      chk($sformatf("vs_out x=%0d y=%0d", pipe[2].x, pipe[2].y), 32'(vs_out), 32'(pipe[2].vs));
    end
    x_in  = 11'(x);
    y_in  = 11'(y);
    hs_in = hs;
    vs_in = vs;
    e.x = x; e.y = y; e.rgb = er; e.hs = hs; e.vs = vs;
    e.ca = eca; e.fa = efa; e.chk = 1'b1; e.chka = chka;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
  endtask

  task automatic step(input int x, input int y, input logic hs, input logic vs, input logic [8:0] er);
    step_a(x, y, hs, vs, er, 1'b0, 12'd0, 11'd0);
  endtask

  task automatic flush();
    repeat (3) step(800, 500, 1'b1, 1'b1, 9'h000);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " rgb"}, 32'(rgb), 32'h0);
    chk({tag, " hs_out"}, 32'(hs_out), 32'h1);
    chk({tag, " vs_out"}, 32'(vs_out), 32'h1);
    chk({tag, " char_addr"}, 32'(char_addr), 32'h0);
    chk({tag, " font_addr"}, 32'(font_addr), 32'h0);
  endtask

  // Asserts rst between edges, holds it for n clocks, releases on a negedge
  // with a blank pixel driven; the pipeline then holds cleared contents.
  task automatic do_reset(input int n);
    exp_t c;
    #5 rst = 1'b0;
    #1 chk_rst("reset asserted");
    repeat (n) begin
      @(negedge clk);
      chk_rst("reset held");
    end
    @(negedge clk);
    rst   = 1'b1;
    x_in  = 11'd800;
    y_in  = 11'd500;
    hs_in = 1'b1;
    vs_in = 1'b1;
    c.x = -1; c.y = -1; c.rgb = 9'h000; c.hs = 1'b1; c.vs = 1'b1;
    c.ca = 12'd0; c.fa = 11'd0; c.chk = 1'b1; c.chka = 1'b0;
    pipe[2] = c;
    pipe[1] = c;
    c.x = 800; c.y = 500;
    pipe[0] = c;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(800, 500, 1'b1, 1'b0, 9'h000);
      step(800, 500, 1'b1, 1'b1, 9'h000);
    end
  endtask

  task automatic scan_cursor(input bit vis);
    int cy[5] = '{32, 45, 46, 47, 48};
    for (int r = 0; r < 5; r++)
      for (int x = 32; x < 56; x++)
        step(x, cy[r], 1'b1, 1'b1,
             (vis && x >= 40 && x <= 47 && cy[r] >= 46 && cy[r] <= 47) ? FG : BG);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] t1[8];
    logic [8:0] t2[16];
    int ys[5] = '{0, 479, 480, 490, 524};
    t1 = '{FG, BG, BG, BG, BG, BG, BG, FG};
    t2 = '{BG, FG, FG, FG, FG, FG, FG, BG, FG, BG, BG, BG, BG, BG, BG, FG};

    do_reset(3);

    // Address generation, font address composition
    step_a(639, 479, 1'b1, 1'b1, FG,     1'b1, 12'd2399, 11'h41F);
    step_a(0,   16,  1'b1, 1'b1, FG,     1'b1, 12'd80,   11'h410);
    step_a(8,   0,   1'b1, 1'b1, FG,     1'b1, 12'd1,    11'h410);
    step_a(640, 0,   1'b1, 1'b1, 9'h000, 1'b1, 12'd0,    11'h410);
    step_a(0,   5,   1'b1, 1'b1, FG,     1'b1, 12'd0,    11'h415);
    flush();

    // Font row 0x81 across one cell
    for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, t1[x]);
    flush();

    // Inverse on cell 0 only
    inv_addr = 12'd0;
    for (int x = 0; x < 16; x++) step(x, 0, 1'b1, 1'b1, t2[x]);
    flush();
    inv_addr = 12'hFFF;

    // Full lines across active and blank regions with sync patterns
    font_val = 8'hFF;
    for (int i = 0; i < 5; i++)
      for (int x = 0; x < 800; x++)
        step(x, ys[i], !(x >= 656 && x < 752), !(ys[i] == 490 || ys[i] == 491),
             (x < 640 && ys[i] < 480) ? FG : 9'h000);
    flush();

    // Cursor blink phases
    font_val   = 8'h00;
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    do_reset(2);
    scan_cursor(1'b0);
    flush();
    pulse_frames(32);
    scan_cursor(1'b1);
    flush();
    cursor_en = 1'b0;
    for (int x = 38; x < 50; x++) step(x, 46, 1'b1, 1'b1, BG);
    flush();
    cursor_en = 1'b1;
    pulse_frames(32);
    scan_cursor(1'b0);
    flush();

    // Mid-frame reset clears outputs and the frame counter
    pulse_frames(32);
    for (int x = 38; x < 50; x++) step(x, 46, 1'b1, 1'b1, (x >= 40 && x <= 47) ? FG : BG);
    flush();
    font_val = 8'hFF;
    for (int x = 296; x <= 300; x++) step(x, 200, 1'b0, 1'b0, FG);
    do_reset(5);
    for (int x = 301; x <= 310; x++) step(x, 200, 1'b1, 1'b1, FG);
    for (int x = 38; x < 50; x++) step(x, 46, 1'b1, 1'b1, FG);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
